// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit holding the HI/LO
// architectural registers. Shift-add multiply and restoring divide retire one
// bit per cycle. The unit runs one IDLE->CALC->ADJ pass of fixed latency and
// then pulses Done.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MtHi,
    input  logic             MtLo,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_ADJ  = 2'd2;

    localparam logic [WIDTH-1:0]   W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   W_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] D_ZERO   = {(2*WIDTH){1'b0}};
    localparam logic [2*WIDTH-1:0] D_ONE    = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

    // Two's-complement negation of a single word.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + W_ONE;
    endfunction

    // Two's-complement negation of a double word (full product).
    function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] v);
        return ~v + D_ONE;
    endfunction

    // Magnitude of an operand; unsigned operations pass the raw value through.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? neg_w(v) : v;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;          // |multiplicand| or shifting |dividend|
    logic [WIDTH-1:0]   b_q, b_d;          // shifting |multiplier| or |divisor|
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;  // raw rs, returned in Hi on divide by zero
    logic [2*WIDTH-1:0] acc_q, acc_d;      // product, or remainder:quotient
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_res_q, neg_res_d;  // negate product / quotient
    logic               neg_rem_q, neg_rem_d;  // negate remainder (sign of A)
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               signed_op_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_rem_s;
    logic [WIDTH:0]     div_sub_s;
    logic               div_ge_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;

    assign signed_op_s = ~Op[0];

    // Datapath for one iteration plus the sign-corrected final results.
    always_comb begin
        mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : {1'b0, W_ZERO});
        div_rem_s = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_ge_s  = (div_rem_s >= {1'b0, b_q});
        div_sub_s = div_rem_s - {1'b0, b_q};
        prod_s    = neg_res_q ? neg_d(acc_q) : acc_q;
        quot_s    = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_s     = neg_rem_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state logic for the IDLE/CALC/ADJ sequencer and all state registers.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        a_raw_d   = a_raw_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    // Start takes priority over any simultaneous MTHI/MTLO.
                    op_d      = Op;
                    a_d       = mag(A, signed_op_s);
                    b_d       = mag(B, signed_op_s);
                    a_raw_d   = A;
                    acc_d     = D_ZERO;
                    cnt_d     = CNT_ZERO;
                    neg_res_d = signed_op_s & (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_rem_d = signed_op_s & A[WIDTH-1];
                    div0_d    = (B == W_ZERO);
                    busy_d    = 1'b1;
                    state_d   = S_CALC;
                end else begin
                    if (MtHi) begin
                        hi_d = WriteData;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (MtLo) begin
                        lo_d = WriteData;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            S_CALC: begin
                if (op_q[1]) begin
                    // Restoring divide: bring in the next dividend bit, try subtract.
                    a_d = {a_q[WIDTH-2:0], 1'b0};
                    if (div_ge_s) begin
                        acc_d = {div_sub_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {div_rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add multiply: the carry out of the add lands in the MSB.
                    b_d   = {1'b0, b_q[WIDTH-1:1]};
                    acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ADJ;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_ADJ: begin
                if (op_q[1]) begin
                    if (div0_q) begin
                        hi_d = a_raw_q;
                        lo_d = W_ONES;
                    end else begin
                        hi_d = rem_s;
                        lo_d = quot_s;
                    end
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            a_q       <= W_ZERO;
            b_q       <= W_ZERO;
            a_raw_q   <= W_ZERO;
            acc_q     <= D_ZERO;
            cnt_q     <= CNT_ZERO;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= W_ZERO;
            lo_q      <= W_ZERO;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_raw_q   <= a_raw_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI:LO pairs are queued at issue
// time and compared by a monitor whenever Done is presented.
module tb_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        MtHi;
    logic        MtLo;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] prev_res;
    logic [63:0] mon_e;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .MtHi(MtHi), .MtLo(MtLo), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse consumes one expected result.
    always @(negedge Clk) begin
        if (Reset_n === 1'b1 && Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: Hi %h Lo %h with no pending result", Hi, Lo);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hi", 64'(Hi), 64'(mon_e[63:32]));
                check("result_lo", 64'(Lo), 64'(mon_e[31:0]));
            end
        end
    end

    // Issue one operation and step through E0..E33, checking Busy/Done timing.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit inject);
        Start = 1'b1; Op = op; A = a; B = b;
        exp_q.push_back(exp);
        @(posedge Clk); #1;
        Start = 1'b0; A = 32'h5555_AAAA; B = 32'h0000_0003;
        check("busy_after_e0", 64'({Busy, Done}), 64'(2'b10));
        for (int i = 1; i <= 33; i++) begin
            if (inject && i == 10) begin
                Start = 1'b1; A = 32'h0000_0001; B = 32'h0000_0001;
                MtLo = 1'b1; MtHi = 1'b1; WriteData = 32'hDEAD_BEEF;
            end
            @(posedge Clk); #1;
            if (inject && i == 10) begin
                Start = 1'b0; MtLo = 1'b0; MtHi = 1'b0;
            end
            if (i == 16) begin
                check("hold_hi", 64'(Hi), 64'(prev_res[63:32]));
                check("hold_lo", 64'(Lo), 64'(prev_res[31:0]));
            end
            if (i < 33) begin
                check("busy_calc", 64'({Busy, Done}), 64'(2'b10));
            end else begin
                check("done_e33", 64'({Busy, Done}), 64'(2'b01));
            end
        end
        prev_res = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; A = 32'h0; B = 32'h0;
        MtHi = 1'b0; MtLo = 1'b0; WriteData = 32'h0;
        prev_res = 64'h0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_hilo", {Hi, Lo}, 64'h0);
        check("reset_busy_done", 64'({Busy, Done}), 64'(2'b00));
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        check("post_reset_hilo", {Hi, Lo}, 64'h0);

        // MTHI only
        WriteData = 32'h1234_5678; MtHi = 1'b1;
        @(posedge Clk); #1;
        MtHi = 1'b0;
        check("mthi", {Hi, Lo}, 64'h12345678_00000000);

        // MTHI and MTLO together
        WriteData = 32'hA5A5_5A5A; MtHi = 1'b1; MtLo = 1'b1;
        @(posedge Clk); #1;
        MtHi = 1'b0; MtLo = 1'b0;
        check("mthi_mtlo", {Hi, Lo}, 64'hA5A55A5A_A5A55A5A);
        prev_res = 64'hA5A55A5A_A5A55A5A;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001, 1'b0);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run_op(OP_DIVU,  32'h0000_0064, 32'h0000_0000, 64'h00000064_FFFFFFFF, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFFFFFB_FFFFFFFF, 1'b0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0);
        // Start/MTHI/MTLO at E10 must be ignored; next Start lands on E34.
        run_op(OP_DIVU,  32'h0000_0032, 32'h0000_0007, 64'h00000001_00000007, 1'b1);
        run_op(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 1'b0);

        // Asynchronous reset in the middle of a MULTU.
        Start = 1'b1; Op = OP_MULTU; A = 32'hFFFF_FFFF; B = 32'h0000_0002;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (15) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("async_reset_hilo", {Hi, Lo}, 64'h0);
        check("async_reset_busy_done", 64'({Busy, Done}), 64'(2'b00));
        #1;
        Reset_n = 1'b1;
        repeat (40) @(posedge Clk);
        #1;
        check("idle_after_abort", 64'({Busy, Done}), 64'(2'b00));
        prev_res = 64'h0;

        run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h00000001_00000000, 1'b0);
        run_op(OP_MULT,  32'h0000_0005, 32'hFFFF_FFFF, 64'hFFFFFFFF_FFFFFFFB, 1'b0);

        @(posedge Clk); #1;
        check("all_results_seen", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative integer multiply/divide unit in the execute stage; consumes the two register-file read operands (ReadData1 → A, ReadData2 → B).
- Holds the architectural HI/LO result registers; results are read back by the datapath mux feeding register-file WriteData (MFHI/MFLO).
- Shift-add multiply and restoring divide, one bit per cycle, fixed latency; the control unit stalls on Busy.

Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is verified. Iteration count equals WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset_n  input  1  asynchronous active-low reset
- Start  input  1  request operation; sampled only in IDLE
- Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- A  input  WIDTH  operand rs (multiplicand/dividend)
- B  input  WIDTH  operand rt (multiplier/divisor)
- MtHi  input  1  write WriteData into Hi (MTHI)
- MtLo  input  1  write WriteData into Lo (MTLO)
- WriteData  input  WIDTH  data for MtHi/MtLo
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse: Hi/Lo hold a new result
- Hi  output  WIDTH  HI register (product high word / remainder)
- Lo  output  WIDTH  LO register (product low word / quotient)

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; Hi=0, Lo=0, Busy=0, Done=0; the in-flight operation is discarded.
- States: IDLE, CALC, ADJ.
- IDLE:
  - Start=1 at edge E0: latch |A|, |B| (absolute values for signed ops, raw values for unsigned), latch Op and the result signs, clear the 2*WIDTH accumulator and the counter; go to CALC; Busy=1.
  - Start=0: MtHi/MtLo write WriteData to Hi/Lo at that edge (both may be asserted together).
  - Start and Mt* together: Start wins; Mt* is ignored.
- CALC: one iteration per edge E1..E32, counter 0..31.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper half; shift the accumulator right 1.
  - Divide: shift the remainder:quotient pair left 1; if remainder ≥ divisor, subtract it and set quotient LSB = 1.
  - After the iteration with counter=31, go to ADJ.
- ADJ (edge E33):
  - Apply sign correction and write Hi/Lo.
  - Set Done=1 for exactly one cycle and Busy=0; return to IDLE.
- Latency: Start sampled at E0; Hi/Lo and Done are valid after E33. A new Start is accepted at E34 (the cycle Done is high).
- Busy is high after E0 through E33, and low when Done is high.
- Start, Mt* and operand changes while Busy=1 are ignored; the operands are latched at E0 only.
- Sign rules:
  - MULT: negate the 64-bit product if sign(A) XOR sign(B).
  - DIV: quotient truncates toward zero and is negated if the signs differ; the remainder takes the sign of A.
- Boundaries:
  - Divide by zero (DIV or DIVU): still 33 cycles; Lo=32'hFFFFFFFF, Hi=A (raw operand).
  - DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0x00000000 (no trap).
  - MULT 0x80000000 * 0x80000000: Hi=0x40000000, Lo=0x00000000.
- Hi/Lo are unchanged from E0 until E33; reads during Busy return the previous values.

Test Plan:
- Reset_n low, then high → Hi=0, Lo=0, Busy=0, Done=0. MtHi=1 with WriteData=0x12345678 → Hi=0x12345678 next cycle; Lo unchanged.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF, Start at E0 → Busy=1 over E1..E33, Done=1 only after E33; Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT A=0xFFFFFFFD (-3) B=7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21). Also MULT 0x80000000*0x80000000 → Hi=0x40000000, Lo=0.
- DIV A=0xFFFFFFF9 (-7) B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=100 B=0 → Lo=0xFFFFFFFF, Hi=100. DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
- During a DIVU 50/7 → Start with new operands plus MtLo=1 at E10 → both ignored; result Lo=7, Hi=1 at E33; Start at E34 accepted.
- Reset_n pulsed low at E15 of a MULTU → Hi=0, Lo=0, Busy=0 immediately (asynchronous); no Done pulse follows; a fresh Start then completes normally in 33 cycles.
